mem_dispatcher__read: RTL
=========================

Name: mem_dispatcher__read

Overview:
- Read-side counterpart of the DDR write dispatcher: copies MACRO_TOP words from external memory, starting at a given byte address, into a local dual-port RAM.
- Transfers in bursts of at most MICRO_TOP words over an MCB-style user port (command channel plus read-data FIFO).
- Sits between the memory controller port and the frame/line buffer RAM that downstream processing consumes.
- Started by a one-cycle os_start; reports busy_unit.

Parameters:
- MICRO_TOP, 32: max words per read burst (1..64).
- MACRO_TOP, 640: total words per transfer; must be ≤ 2^RAM_ADDR_BITS.
- RAM_ADDR_BITS, 10: local RAM address width.
- DDR_PORT_BITS, 32: data width of the memory port and the RAM.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- os_start  in  1  start request, sampled only in IDLE.
- init_mem_addr  in  30  byte address of the first word, latched on accepted start.
- busy_unit  out  1  high unless in IDLE.
- done_pulse  out  1  one-cycle pulse when the last word is written to RAM.
- rd_overflow_err  out  1  sticky; set when port_rd_overflow is seen, cleared on accepted start.
- data_out__addr  out  RAM_ADDR_BITS  RAM write address.
- data_out  out  DDR_PORT_BITS  RAM write data.
- data_out__we  out  1  RAM write enable.
- mem_calib_done  in  1  memory controller calibrated.
- port_cmd_en  out  1  command strobe, one cycle per burst.
- port_cmd_instr  out  3  always 3'b001 (read).
- port_cmd_bl  out  6  burst length minus 1.
- port_cmd_byte_addr  out  30  burst byte address.
- port_rd_en  out  1  read-FIFO pop.
- port_rd_data  in  DDR_PORT_BITS  read-FIFO data.
- port_rd_empty  in  1  read FIFO empty.
- port_rd_overflow  in  1  read FIFO overflow.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state = WAIT_CALIB, busy_unit = 1.
  - done_pulse, rd_overflow_err, data_out__we, port_cmd_en = 0.
  - port_cmd_instr = 3'b001, port_cmd_bl = 0, port_cmd_byte_addr = 0, data_out__addr = 0, data_out = 0.
  - All counters = 0.
- port_rd_en is combinational: (state == DRAIN or state == IDLE) and ~port_rd_empty. A pop occurs when port_rd_en is high.
- Burst byte increment BURST_BYTES = MICRO_TOP*(DDR_PORT_BITS/8), which is 128 at the defaults.
- Counters:
  - total_cnt counts words written this transfer; width clog2(MACRO_TOP+1).
  - burst_cnt counts words received in the current burst; 7 bits.
  - remaining = MACRO_TOP - total_cnt.
- States:
  - WAIT_CALIB: busy_unit = 1. Go to IDLE when mem_calib_done = 1. os_start is ignored.
  - IDLE:
    - busy_unit = 0.
    - Any words left in the read FIFO, e.g. from a burst aborted by reset, are popped and discarded; data_out__we stays 0.
    - On os_start with port_rd_empty = 1: latch init_mem_addr into port_cmd_byte_addr, clear total_cnt, clear rd_overflow_err, set busy_unit = 1, go to ISSUE. If the FIFO is not empty, the start is held off until the cycle it reads empty; os_start must be held by the requester.
  - ISSUE (1 cycle):
    - port_cmd_en = 1.
    - port_cmd_bl = min(MICRO_TOP, remaining) - 1.
    - Save that length as burst_len; burst_cnt = 0; go to DRAIN.
    - port_cmd_en is 0 in every other state.
  - DRAIN:
    - Each pop registers, one cycle later: data_out__we = 1, data_out = port_rd_data, data_out__addr = total_cnt (value before increment).
    - On each pop, total_cnt and burst_cnt increment.
    - When the pop makes burst_cnt reach burst_len:
      - If remaining becomes 0, go to DONE.
      - Otherwise add BURST_BYTES to port_cmd_byte_addr and go to ISSUE.
    - Only one burst is outstanding at a time.
  - DONE (1 cycle): done_pulse = 1 (registered, aligned with the final data_out__we). Go to IDLE. busy_unit falls in the IDLE cycle.
- Latency:
  - os_start to port_cmd_en = 1 cycle.
  - Pop to RAM write = 1 cycle.
  - Idle time between bursts = 1 cycle (the ISSUE state).
- Boundary conditions:
  - MACRO_TOP not a multiple of MICRO_TOP: the last burst is shorter; bl = remainder - 1.
  - port_rd_overflow = 1 in any state sets rd_overflow_err. The transfer continues.
  - os_start while busy: ignored.
  - mem_calib_done dropping after calibration: no effect.
  - The 30-bit address addition wraps modulo 2^30.

Decomposition:
- Shared package mem_dispatcher_pkg holds:
  - state encoding;
  - MCB instruction constants CMD_WRITE = 3'b000 and CMD_READ = 3'b001;
  - a clog2 function.
- The write dispatcher uses the same package.
- No sub-module; a single FSM with counters.

Test Plan:
- Defaults, calib high, os_start with init_mem_addr = 0x1000, and a FIFO model returning a word pattern equal to the address → 20 commands:
  - bl = 31 each;
  - addresses 0x1000, 0x1080, … 0x1980;
  - RAM addresses 0..639 hold the pattern;
  - done_pulse once, one cycle after the last word.
- MACRO_TOP = 100, MICRO_TOP = 32 → four commands with bl = 31, 31, 31, 3; exactly 100 RAM writes.
- port_rd_empty toggling randomly at 50% → no duplicated or skipped RAM addresses; data_out__we only one cycle after a pop.
- os_start held before mem_calib_done → no command until calib, then start accepted; os_start pulsed mid-transfer → ignored.
- rst_n asserted mid-DRAIN with 10 words still in the FIFO:
  - outputs at reset values immediately;
  - after calib, IDLE discards the 10 words with no RAM writes;
  - the next transfer then completes correctly.
- port_rd_overflow pulsed → rd_overflow_err = 1 and stays set until the next accepted start.

Source files
------------

// File: rtl/mem_dispatcher_pkg.sv
// Shared definitions for the DDR read and write dispatchers: FSM state
// encoding, MCB command opcodes and a constant-friendly clog2 helper.
package mem_dispatcher_pkg;

  typedef enum logic [2:0] {
    WAIT_CALIB = 3'd0,
    IDLE       = 3'd1,
    ISSUE      = 3'd2,
    DRAIN      = 3'd3,
    DONE       = 3'd4
  } disp_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Ceiling log2 with a floor of one bit so a counter always has a width.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_dispatcher__read_if.sv
// MCB-style user port: read command channel plus read-data FIFO.
// The dispatcher is the master; the memory controller side is the slave.
interface mem_dispatcher__read_if #(
  parameter int DATA_BITS = 32
);

  logic                 port_cmd_en;
  logic [2:0]           port_cmd_instr;
  logic [5:0]           port_cmd_bl;
  logic [29:0]          port_cmd_byte_addr;
  logic                 port_rd_en;
  logic [DATA_BITS-1:0] port_rd_data;
  logic                 port_rd_empty;
  logic                 port_rd_overflow;

  modport master (
    output port_cmd_en,
    output port_cmd_instr,
    output port_cmd_bl,
    output port_cmd_byte_addr,
    output port_rd_en,
    input  port_rd_data,
    input  port_rd_empty,
    input  port_rd_overflow
  );

  modport slave (
    input  port_cmd_en,
    input  port_cmd_instr,
    input  port_cmd_bl,
    input  port_cmd_byte_addr,
    input  port_rd_en,
    output port_rd_data,
    output port_rd_empty,
    output port_rd_overflow
  );

endinterface

// File: rtl/mem_dispatcher__read.sv
// Read dispatcher: copies MACRO_TOP words from external memory into a local
// RAM, issuing one read burst of up to MICRO_TOP words at a time and
// draining the controller's read FIFO into consecutive RAM addresses.
module mem_dispatcher__read
  import mem_dispatcher_pkg::*;
#(
  parameter int MICRO_TOP     = 32,
  parameter int MACRO_TOP     = 640,
  parameter int RAM_ADDR_BITS = 10,
  parameter int DDR_PORT_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     os_start,
  input  logic [29:0]              init_mem_addr,
  output logic                     busy_unit,
  output logic                     done_pulse,
  output logic                     rd_overflow_err,
  output logic [RAM_ADDR_BITS-1:0] data_out__addr,
  output logic [DDR_PORT_BITS-1:0] data_out,
  output logic                     data_out__we,
  input  logic                     mem_calib_done,
  mem_dispatcher__read_if.master   mcb
);

  localparam int TOTAL_W = clog2(MACRO_TOP + 1);
  localparam logic [29:0] BURST_BYTES = 30'(MICRO_TOP * (DDR_PORT_BITS / 8));
  localparam logic [TOTAL_W-1:0] MACRO_LAST = TOTAL_W'(MACRO_TOP);

  disp_state_t        state;
  logic [TOTAL_W-1:0] total_cnt;
  logic [TOTAL_W-1:0] total_inc;
  logic [6:0]         burst_cnt;
  logic [6:0]         burst_inc;
  logic [6:0]         burst_len;
  logic               pop;
  logic               last_in_burst;
  logic               last_in_xfer;

  // Length of the next burst given how many words are already written.
  function automatic logic [6:0] burst_length(input logic [TOTAL_W-1:0] words_done);
    int rem;
    rem = MACRO_TOP - int'(words_done);
    if (rem > MICRO_TOP) begin
      rem = MICRO_TOP;
    end
    return 7'(rem);
  endfunction

  // The FIFO is popped while draining a burst, and also in IDLE so that
  // leftovers from an aborted burst are flushed before the next start.
  assign mcb.port_rd_en     = ((state == DRAIN) || (state == IDLE)) && !mcb.port_rd_empty;
  assign mcb.port_cmd_instr = CMD_READ;

  assign pop           = mcb.port_rd_en;
  assign total_inc     = total_cnt + TOTAL_W'(1);
  assign burst_inc     = burst_cnt + 7'd1;
  assign last_in_burst = (burst_inc == burst_len);
  assign last_in_xfer  = (total_inc == MACRO_LAST);

  // Main FSM with counters; commands and RAM writes are issued as registered
  // outputs on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= WAIT_CALIB;
      busy_unit              <= 1'b1;
      done_pulse             <= 1'b0;
      rd_overflow_err        <= 1'b0;
      data_out__we           <= 1'b0;
      data_out__addr         <= '0;
      data_out               <= '0;
      mcb.port_cmd_en        <= 1'b0;
      mcb.port_cmd_bl        <= '0;
      mcb.port_cmd_byte_addr <= '0;
      total_cnt              <= '0;
      burst_cnt              <= '0;
      burst_len              <= '0;
    end else begin
      done_pulse      <= 1'b0;
      data_out__we    <= 1'b0;
      mcb.port_cmd_en <= 1'b0;
      if (mcb.port_rd_overflow) begin
        rd_overflow_err <= 1'b1;
      end
      case (state)
        WAIT_CALIB: begin
          if (mem_calib_done) begin
            state     <= IDLE;
            busy_unit <= 1'b0;
          end
        end
        IDLE: begin
          if (os_start && mcb.port_rd_empty) begin
            mcb.port_cmd_byte_addr <= init_mem_addr;
            total_cnt              <= '0;
            rd_overflow_err        <= mcb.port_rd_overflow;
            busy_unit              <= 1'b1;
            mcb.port_cmd_en        <= 1'b1;
            mcb.port_cmd_bl        <= 6'(burst_length('0) - 7'd1);
            burst_len              <= burst_length('0);
            burst_cnt              <= '0;
            state                  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= DRAIN;
        end
        DRAIN: begin
          if (pop) begin
            data_out__we   <= 1'b1;
            data_out       <= mcb.port_rd_data;
            data_out__addr <= RAM_ADDR_BITS'(total_cnt);
            total_cnt      <= total_inc;
            burst_cnt      <= burst_inc;
            if (last_in_burst) begin
              if (last_in_xfer) begin
                done_pulse <= 1'b1;
                state      <= DONE;
              end else begin
                mcb.port_cmd_byte_addr <= mcb.port_cmd_byte_addr + BURST_BYTES;
                mcb.port_cmd_en        <= 1'b1;
                mcb.port_cmd_bl        <= 6'(burst_length(total_inc) - 7'd1);
                burst_len              <= burst_length(total_inc);
                burst_cnt              <= '0;
                state                  <= ISSUE;
              end
            end
          end
        end
        DONE: begin
          busy_unit <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy_unit <= 1'b1;
          state     <= WAIT_CALIB;
        end
      endcase
    end
  end

endmodule
